// File: rtl/commit_trace_buf_pkg.sv
// commit_trace_pkg: shared types for the commit trace buffer.
//   - trace entry struct and its packed width (ENTRY_W)
//   - flag bit positions inside trace_entry_t.flags
//   - run/freeze state encoding
// Build option: TRACE_TIMESTAMP_EN adds a TS_W-bit timestamp field
// in the MSBs of each entry.
package commit_trace_pkg;

  localparam int unsigned FLAG_W         = 4;
  localparam int unsigned FLAG_REG_WRITE = 0;
  localparam int unsigned FLAG_MEM_READ  = 1;
  localparam int unsigned FLAG_MEM_WRITE = 2;
  localparam int unsigned FLAG_HALT      = 3;

  // Packages cannot follow the CNT_W parameter of the top module.
  // The stamp therefore carries the low TS_W bits of the cycle counter.
  localparam int unsigned TS_W = 16;

  typedef struct packed {
`ifdef TRACE_TIMESTAMP_EN
    logic [TS_W-1:0]   ts;
`endif
    logic [FLAG_W-1:0] flags;
    logic [2:0]        write_reg;
    logic [15:0]       write_data;
    logic [15:0]       mem_addr;
    logic [15:0]       mem_data;
  } trace_entry_t;

`ifdef TRACE_TIMESTAMP_EN
  localparam int unsigned ENTRY_W = TS_W + FLAG_W + 3 + 16 + 16 + 16;
`else
  localparam int unsigned ENTRY_W = FLAG_W + 3 + 16 + 16 + 16;
`endif

  typedef enum logic {
    ST_RUN,
    ST_FROZEN
  } run_state_t;

  function automatic logic [FLAG_W-1:0] pack_flags(
    input logic halt,
    input logic mem_write,
    input logic mem_read,
    input logic reg_write
  );
    logic [FLAG_W-1:0] f;
    f                 = '0;
    f[FLAG_HALT]      = halt;
    f[FLAG_MEM_WRITE] = mem_write;
    f[FLAG_MEM_READ]  = mem_read;
    f[FLAG_REG_WRITE] = reg_write;
    return f;
  endfunction

endpackage

// File: rtl/commit_trace_buf_if.sv
// commit_trace_buf_if: read-side handshake of the commit trace buffer.
//   rd_valid : head entry available          (buffer -> consumer)
//   rd_ready : consumer accepts head entry    (consumer -> buffer)
//   rd_entry : oldest entry (trace_entry_t)   (buffer -> consumer)
// Modports: master = buffer side, slave = consumer side.
interface commit_trace_buf_if;
  import commit_trace_pkg::*;

  logic         rd_valid;
  logic         rd_ready;
  trace_entry_t rd_entry;

  modport master (
    output rd_valid,
    output rd_entry,
    input  rd_ready
  );

  modport slave (
    input  rd_valid,
    input  rd_entry,
    output rd_ready
  );

endinterface

// File: rtl/commit_trace_buf_fifo.sv
// trace_fifo: synchronous FIFO storage for the commit trace buffer.
// Ports:
//   clk, rst  : clock, synchronous active-high reset (empties the FIFO)
//   i_push    : write request; ignored when full unless a pop happens too
//   i_data    : write data (WIDTH bits)
//   i_pop     : read request; ignored when empty
//   o_data    : head entry (valid while o_empty = 0)
//   o_full    : DEPTH entries held
//   o_empty   : no entries held
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module trace_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_pop;
  logic             w_do_push;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

  assign w_do_pop  = i_pop & ~o_empty;
  // A pop in the same cycle frees the head slot, so a full FIFO still accepts.
  assign w_do_push = i_push & (~o_full | w_do_pop);

  assign o_data = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/commit_trace_buf.sv
// commit_trace_buf: captures retiring-instruction events into a trace FIFO.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   reg_write/write_reg/write_data        : register file write
//   mem_read/mem_write/mem_addr           : data memory access
//   mem_data_in / mem_data_out            : store data / load data
//   halt                     : halt retiring; freezes capture
//   rd (commit_trace_buf_if.master)       : rd_valid / rd_ready / rd_entry
//   overflow                 : sticky, at least one event dropped
//   frozen                   : halt captured, capture stopped
//   inst_count / drop_count  : saturating retired / dropped counters
// Build option: TRACE_TIMESTAMP_EN adds a free-running cycle counter whose
// value at push time is stored in each entry.
module commit_trace_buf
  import commit_trace_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               reg_write,
  input  logic [2:0]         write_reg,
  input  logic [15:0]        write_data,
  input  logic               mem_read,
  input  logic               mem_write,
  input  logic [15:0]        mem_addr,
  input  logic [15:0]        mem_data_in,
  input  logic [15:0]        mem_data_out,
  input  logic               halt,
  commit_trace_buf_if.master rd,
  output logic               overflow,
  output logic               frozen,
  output logic [CNT_W-1:0]   inst_count,
  output logic [CNT_W-1:0]   drop_count
);

  run_state_t       r_state;
  logic             r_overflow;
  logic [CNT_W-1:0] r_inst_cnt;
  logic [CNT_W-1:0] r_drop_cnt;

  logic               w_active;
  logic               w_event;
  logic               w_counts;
  logic               w_pop;
  logic               w_drop;
  logic               w_full;
  logic               w_empty;
  trace_entry_t       w_entry;
  logic [ENTRY_W-1:0] w_entry_bits;
  logic [ENTRY_W-1:0] w_head_bits;

`ifdef TRACE_TIMESTAMP_EN
  logic [CNT_W-1:0] r_cycle;
`endif

  assign w_active = (r_state == ST_RUN);
  assign w_event  = w_active & (reg_write | mem_read | mem_write | halt);
  assign w_counts = w_active & (halt | reg_write | mem_write);
  assign w_pop    = rd.rd_ready & ~w_empty;
  assign w_drop   = w_event & w_full & ~w_pop;

  always_comb begin
    w_entry       = '0;
    w_entry.flags = pack_flags(halt, mem_write, mem_read, reg_write);
    if (reg_write) begin
      w_entry.write_reg  = write_reg;
      w_entry.write_data = write_data;
    end
    if (mem_read | mem_write) w_entry.mem_addr = mem_addr;
    if (mem_read)       w_entry.mem_data = mem_data_out;
    else if (mem_write) w_entry.mem_data = mem_data_in;
`ifdef TRACE_TIMESTAMP_EN
    w_entry.ts = TS_W'(r_cycle);
`endif
  end

  assign w_entry_bits = w_entry;

  trace_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_event),
    .i_data  (w_entry_bits),
    .i_pop   (rd.rd_ready),
    .o_data  (w_head_bits),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign rd.rd_valid = ~w_empty;
  assign rd.rd_entry = trace_entry_t'(w_head_bits);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_RUN;
      r_overflow <= 1'b0;
      r_inst_cnt <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (w_counts && (r_inst_cnt != '1))
        r_inst_cnt <= r_inst_cnt + CNT_W'(1);
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + CNT_W'(1);
      end
      // A halt freezes capture whether its entry was stored or dropped.
      if (w_event && halt) r_state <= ST_FROZEN;
    end
  end

`ifdef TRACE_TIMESTAMP_EN
  always_ff @(posedge clk) begin
    if (rst)           r_cycle <= '0;
    else if (w_active) r_cycle <= r_cycle + CNT_W'(1);
  end
`endif

  assign overflow   = r_overflow;
  assign frozen     = (r_state == ST_FROZEN);
  assign inst_count = r_inst_cnt;
  assign drop_count = r_drop_cnt;

endmodule

// File: tb/tb_commit_trace_buf.sv
module tb_commit_trace_buf;
  import commit_trace_pkg::*;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             reg_write;
  logic [2:0]       write_reg;
  logic [15:0]      write_data;
  logic             mem_read;
  logic             mem_write;
  logic [15:0]      mem_addr;
  logic [15:0]      mem_data_in;
  logic [15:0]      mem_data_out;
  logic             halt;
  logic             overflow;
  logic             frozen;
  logic [CNT_W-1:0] inst_count;
  logic [CNT_W-1:0] drop_count;

  commit_trace_buf_if rd_if ();

  commit_trace_buf #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .reg_write    (reg_write),
    .write_reg    (write_reg),
    .write_data   (write_data),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_addr     (mem_addr),
    .mem_data_in  (mem_data_in),
    .mem_data_out (mem_data_out),
    .halt         (halt),
    .rd           (rd_if),
    .overflow     (overflow),
    .frozen       (frozen),
    .inst_count   (inst_count),
    .drop_count   (drop_count)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    reg_write    = 1'b0;
    write_reg    = '0;
    write_data   = '0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    mem_addr     = '0;
    mem_data_in  = '0;
    mem_data_out = '0;
    halt         = 1'b0;
  endtask

  // Pops until empty (bounded); returns count plus first and last entries.
  task automatic drain(output int n, output trace_entry_t first, output trace_entry_t last);
    n     = 0;
    first = '0;
    last  = '0;
    rd_if.rd_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (!rd_if.rd_valid) break;
      if (n == 0) first = rd_if.rd_entry;
      last = rd_if.rd_entry;
      n++;
      tick();
    end
    rd_if.rd_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int           n;
    trace_entry_t e_first;
    trace_entry_t e_last;

    idle_inputs();
    rd_if.rd_ready = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    chk("rst_valid", 32'(rd_if.rd_valid), 32'd0);
    chk("rst_ovf",   32'(overflow),       32'd0);
    chk("rst_frz",   32'(frozen),         32'd0);
    chk("rst_inst",  32'(inst_count),     32'd0);
    chk("rst_drop",  32'(drop_count),     32'd0);
    rst = 1'b0;

    // Register write r3 = 0x1234
    reg_write = 1'b1; write_reg = 3'd3; write_data = 16'h1234;
    tick();
    idle_inputs();
    chk("rw_valid", 32'(rd_if.rd_valid),            32'd1);
    chk("rw_flags", 32'(rd_if.rd_entry.flags),      32'h1);
    chk("rw_reg",   32'(rd_if.rd_entry.write_reg),  32'd3);
    chk("rw_data",  32'(rd_if.rd_entry.write_data), 32'h1234);
    chk("rw_addr0", 32'(rd_if.rd_entry.mem_addr),   32'h0);
    chk("rw_mdat0", 32'(rd_if.rd_entry.mem_data),   32'h0);
    chk("rw_inst",  32'(inst_count),                32'd1);
    tick();
    chk("rw_hold_valid", 32'(rd_if.rd_valid),            32'd1);
    chk("rw_hold_data",  32'(rd_if.rd_entry.write_data), 32'h1234);
    drain(n, e_first, e_last);
    chk("rw_drain_n", 32'(n), 32'd1);

    // Load: reg_write + mem_read
    reg_write = 1'b1; write_reg = 3'd5; write_data = 16'hBEEF;
    mem_read = 1'b1; mem_addr = 16'h0040; mem_data_out = 16'hBEEF; mem_data_in = 16'h1111;
    tick();
    idle_inputs();
    chk("ld_flags", 32'(rd_if.rd_entry.flags),     32'h3);
    chk("ld_reg",   32'(rd_if.rd_entry.write_reg), 32'd5);
    chk("ld_addr",  32'(rd_if.rd_entry.mem_addr),  32'h0040);
    chk("ld_mdat",  32'(rd_if.rd_entry.mem_data),  32'hBEEF);
    chk("ld_inst",  32'(inst_count),               32'd2);
    drain(n, e_first, e_last);
    chk("ld_drain_n", 32'(n), 32'd1);

    // mem_read alone: entry captured but not counted as retired
    mem_read = 1'b1; mem_addr = 16'h0010; mem_data_out = 16'h0055; mem_data_in = 16'hAAAA;
    tick();
    idle_inputs();
    chk("mr_valid", 32'(rd_if.rd_valid),            32'd1);
    chk("mr_flags", 32'(rd_if.rd_entry.flags),      32'h2);
    chk("mr_mdat",  32'(rd_if.rd_entry.mem_data),   32'h0055);
    chk("mr_wdat0", 32'(rd_if.rd_entry.write_data), 32'h0);
    chk("mr_inst",  32'(inst_count),                32'd2);
    drain(n, e_first, e_last);

    // 20 stores into a 16-deep buffer with no consumer
    for (int i = 0; i < 20; i++) begin
      mem_write = 1'b1; mem_addr = 16'(i); mem_data_in = 16'(16'h0100 + i);
      write_data = 16'hDEAD;
      tick();
    end
    idle_inputs();
    chk("ov_flag",  32'(overflow),                  32'd1);
    chk("ov_drop",  32'(drop_count),                32'd4);
    chk("ov_inst",  32'(inst_count),                32'd22);
    chk("ov_flags", 32'(rd_if.rd_entry.flags),      32'h4);
    chk("ov_addr",  32'(rd_if.rd_entry.mem_addr),   32'h0);
    chk("ov_mdat",  32'(rd_if.rd_entry.mem_data),   32'h0100);
    chk("ov_wdat0", 32'(rd_if.rd_entry.write_data), 32'h0);

    // Full buffer: push and pop in the same cycle
    mem_write = 1'b1; mem_addr = 16'h0077; mem_data_in = 16'h0177;
    rd_if.rd_ready = 1'b1;
    tick();
    idle_inputs();
    rd_if.rd_ready = 1'b0;
    chk("fp_drop",  32'(drop_count),              32'd4);
    chk("fp_inst",  32'(inst_count),              32'd23);
    chk("fp_head",  32'(rd_if.rd_entry.mem_addr), 32'h0001);
    drain(n, e_first, e_last);
    chk("fp_drain_n",   32'(n),                32'd16);
    chk("fp_first",     32'(e_first.mem_addr), 32'h0001);
    chk("fp_last_addr", 32'(e_last.mem_addr),  32'h0077);
    chk("fp_last_mdat", 32'(e_last.mem_data),  32'h0177);

    // rd_ready while empty has no effect
    rd_if.rd_ready = 1'b1;
    tick();
    rd_if.rd_ready = 1'b0;
    chk("em_valid", 32'(rd_if.rd_valid), 32'd0);
    chk("em_drop",  32'(drop_count),     32'd4);

    // Halt, then a store that must not be captured
    halt = 1'b1;
    tick();
    idle_inputs();
    mem_write = 1'b1; mem_addr = 16'h0099; mem_data_in = 16'h0999;
    chk("ht_frozen", 32'(frozen),     32'd1);
    chk("ht_inst",   32'(inst_count), 32'd24);
    tick();
    idle_inputs();
    chk("ht_inst_hold", 32'(inst_count),             32'd24);
    chk("ht_drop_hold", 32'(drop_count),             32'd4);
    chk("ht_flags",     32'(rd_if.rd_entry.flags),   32'h8);
    chk("ht_addr0",     32'(rd_if.rd_entry.mem_addr), 32'h0);
    tick();
    drain(n, e_first, e_last);
    chk("ht_drain_n",  32'(n),            32'd1);
    chk("ht_last_flg", 32'(e_last.flags), 32'h8);
    chk("ht_frz_kept", 32'(frozen),       32'd1);

    // Reset with entries queued and a push pending
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("r2_frz", 32'(frozen), 32'd0);
    for (int i = 0; i < 5; i++) begin
      mem_write = 1'b1; mem_addr = 16'(16'h0200 + i); mem_data_in = 16'(i);
      tick();
    end
    idle_inputs();
    chk("r2_inst5", 32'(inst_count), 32'd5);
    rst = 1'b1;
    reg_write = 1'b1; write_reg = 3'd1; mem_write = 1'b1; mem_addr = 16'h0300;
    tick();
    rst = 1'b0;
    idle_inputs();
    chk("r2_valid", 32'(rd_if.rd_valid), 32'd0);
    chk("r2_inst",  32'(inst_count),     32'd0);
    chk("r2_drop",  32'(drop_count),     32'd0);
    chk("r2_ovf",   32'(overflow),       32'd0);
    chk("r2_frz2",  32'(frozen),         32'd0);
    tick();
    reg_write = 1'b1; write_reg = 3'd7; write_data = 16'h0077;
    tick();
    idle_inputs();
    chk("r2_post_valid", 32'(rd_if.rd_valid),            32'd1);
    chk("r2_post_data",  32'(rd_if.rd_entry.write_data), 32'h0077);
    chk("r2_post_inst",  32'(inst_count),                32'd1);
`ifdef TRACE_TIMESTAMP_EN
    chk("r2_post_ts",    32'(rd_if.rd_entry.ts),         32'd1);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/commit_trace_buf.md
COMMIT_TRACE_BUF -- requirements
Module: commit_trace_buf

Interface
REQ-001 SHALL have parameter DEPTH, default 16, number of trace entries; power of two, 2..256.
REQ-002 SHALL have parameter CNT_W, default 16, width of the instruction, drop and cycle counters.
REQ-003 SHALL use one clock; reset is synchronous and active-high; ports named clk and rst.
REQ-004 SHALL have ports (name direction width meaning):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- reg_write  in  1  register file write this cycle
- write_reg  in  3  destination register
- write_data  in  16  register write data
- mem_read  in  1  data memory read (read qualified with enable)
- mem_write  in  1  data memory write (write qualified with enable)
- mem_addr  in  16  data memory address
- mem_data_in  in  16  store data
- mem_data_out  in  16  load data
- halt  in  1  halt retiring
- rd_valid  out  1  entry available at head
- rd_ready  in  1  consumer accepts head entry
- rd_entry  out  ENTRY_W  head entry (package type)
- overflow  out  1  sticky: at least one event dropped
- frozen  out  1  halt captured; capture stopped
- inst_count  out  CNT_W  retired-instruction count
- drop_count  out  CNT_W  dropped-event count

Function
REQ-005 SHALL form an event when not frozen and any of reg_write, mem_read, mem_write, halt is 1.
REQ-006 SHALL pack each event as one entry: flags {halt, mem_write, mem_read, reg_write}, write_reg, write_data, mem_addr, mem_data (mem_data_out if mem_read, else mem_data_in); entry fields SHALL be zero when their flag is 0.
REQ-007 SHALL push at most one entry per cycle; an entry pushed in cycle N SHALL be visible at rd_entry with rd_valid=1 no earlier than cycle N+1.
REQ-008 SHALL assert rd_valid iff occupancy > 0; rd_entry SHALL be the oldest entry and hold stable while rd_valid=1 and rd_ready=0.
REQ-009 SHALL pop on rd_valid & rd_ready; rd_ready while empty SHALL have no effect.
REQ-010 SHALL, when full with no pop, drop the event, set overflow, and increment drop_count (saturating at all-ones).
REQ-011 SHALL, when full with simultaneous pop and push, accept the push; occupancy unchanged, no drop.
REQ-012 SHALL wrap read and write pointers modulo DEPTH; full/empty determined by an extra pointer wrap bit.
REQ-013 SHALL increment inst_count by 1 in each non-frozen cycle with halt | reg_write | mem_write (saturating); mem_read alone SHALL NOT count.
REQ-014 SHALL, on an accepted or dropped halt event, set frozen from the next cycle; while frozen, no events, inst_count and drop_count hold; draining via rd_ready continues.
REQ-015 SHALL count events and drops identically whether or not the consumer is popping.

Reset
REQ-016 SHALL on rst=1 at a clk edge: empty buffer, rd_valid=0, overflow=0, frozen=0, inst_count=0, drop_count=0; rd_entry value don't-care while rd_valid=0.
REQ-017 SHALL give rst priority over push, pop and halt in the same cycle; reset mid-drain discards all entries.

Configuration
REQ-018 SHALL, with TRACE_TIMESTAMP_EN defined, maintain a free-running CNT_W-bit cycle counter (reset 0, wraps, stops when frozen) and append its value at push time to each entry.
REQ-019 SHALL, without TRACE_TIMESTAMP_EN, have no cycle counter and no timestamp field; ENTRY_W shrinks accordingly.

Structure
REQ-020 SHALL place the entry struct, flag bit positions, and ENTRY_W (both macro variants) in package commit_trace_pkg.
REQ-021 SHALL implement storage as sub-module trace_fifo (parameterised depth/width, push/pop/full/empty); event packing, counters and freeze logic stay in commit_trace_buf.

Verification
REQ-022 Reg write r3=0x1234, rd_ready=0 -> next cycle rd_valid=1, flags=0001, write_reg=3, write_data=0x1234; inst_count=1.
REQ-023 Load: reg_write + mem_read, addr 0x0040, data_out 0xBEEF -> one entry, flags=0011, mem_data=0xBEEF; inst_count +1.
REQ-024 DEPTH=16, 20 consecutive stores, rd_ready=0 -> 16 entries held, overflow=1, drop_count=4, inst_count=20.
REQ-025 Full buffer, push and rd_ready=1 same cycle -> drop_count unchanged, occupancy stays 16, head advances by one.
REQ-026 Halt then store next cycle -> halt entry flags=1000, frozen=1, store not captured, inst_count unchanged; drain yields halt entry last.
REQ-027 rst asserted with 5 entries queued and a push pending -> next cycle rd_valid=0, counters 0, frozen=0; with TRACE_TIMESTAMP_EN, first post-reset event stamped by cycle count since reset.
